// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one shared memory port
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [1:0]  dm_size,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_err,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int SW = (STARVE_LIMIT < 8) ? 3 : $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
  localparam logic [31:0]   NOP_INSN   = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] to_cnt;

  logic          dm_legal;
  logic [3:0]    dm_be;
  logic [31:0]   dm_lanes;

  logic          grant_if;
  logic          grant_dm;
  logic          launch_dm;
  logic          reject_dm;
  logic          done_ack;
  logic          done_to;

  // Fetch addresses are word aligned by construction; the low bits carry no information.
  logic          unused_if_lo;
  assign unused_if_lo = &{1'b0, if_addr[1:0]};

  // Decode the data request: legality, byte enables and lane-replicated store data
  always_comb begin
    dm_legal = 1'b0;
    dm_be    = 4'b0000;
    dm_lanes = dm_wdata;
    case (dm_size)
      2'b00: begin
        dm_legal = 1'b1;
        dm_be    = 4'b0001 << dm_addr[1:0];
        dm_lanes = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        dm_legal = ~dm_addr[0];
        dm_be    = dm_addr[1] ? 4'b1100 : 4'b0011;
        dm_lanes = {2{dm_wdata[15:0]}};
      end
      2'b10: begin
        dm_legal = (dm_addr[1:0] == 2'b00);
        dm_be    = 4'b1111;
        dm_lanes = dm_wdata;
      end
      default: begin
        dm_legal = 1'b0;
        dm_be    = 4'b0000;
        dm_lanes = dm_wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: grant from IDLE, return to IDLE on ack or timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_next = IF_BUSY;
        end else if (launch_dm) begin
          state_next = DM_BUSY;
        end
      end
      IF_BUSY, DM_BUSY: begin
        if (done_ack || done_to) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode: arbitration decisions and completion events for this cycle
  always_comb begin
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    launch_dm = 1'b0;
    reject_dm = 1'b0;
    done_ack  = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        // Data wins unless the fetch side has waited through STARVE_LIMIT data grants
        grant_dm  = dm_req & (~if_req | (starve_cnt < STARVE_MAX));
        grant_if  = if_req & (~dm_req | (starve_cnt == STARVE_MAX));
        launch_dm = grant_dm & dm_legal;
        reject_dm = grant_dm & ~dm_legal;
      end
      IF_BUSY, DM_BUSY: begin
        done_ack = mem_ack;
        done_to  = ~mem_ack & (to_cnt == TO_LAST);
      end
      default: ;
    endcase
  end

  // Starvation counter: counts data grants the waiting fetch has lost, saturating
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!if_req || grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && (starve_cnt < STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Timeout counter: number of busy cycles already spent waiting for mem_ack
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Registered memory port and completion outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_valid  <= 1'b0;
      dm_err    <= 1'b0;
      dm_rdata  <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      dm_err   <= 1'b0;

      if (grant_if) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= {if_addr[31:2], 2'b00};
        mem_wdata <= '0;
        mem_be    <= 4'b1111;
      end else if (launch_dm) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_we;
        mem_addr  <= {dm_addr[31:2], 2'b00};
        mem_wdata <= dm_lanes;
        mem_be    <= dm_be;
      end else if (reject_dm) begin
        // Bad size or alignment never reaches memory; answer with an error at once
        dm_valid <= 1'b1;
        dm_err   <= 1'b1;
        dm_rdata <= '0;
      end

      if (done_ack) begin
        mem_req <= 1'b0;
        if (state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          dm_valid <= 1'b1;
          dm_rdata <= mem_rdata;
        end
      end else if (done_to) begin
        // Memory went silent: complete anyway, a fetch sees a NOP, data sees an error
        mem_req <= 1'b0;
        if (state == IF_BUSY) begin
          if_valid <= 1'b1;
          if_rdata <= NOP_INSN;
        end else begin
          dm_valid <= 1'b1;
          dm_err   <= 1'b1;
          dm_rdata <= '0;
        end
      end
    end
  end

  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;

endmodule
